// File: rtl/result_display_sequencer.sv
// result_display_sequencer
// Buffers 64-bit ALU results in a small FIFO and shows each one on the
// seven-segment driver as four 16-bit slices. The most significant slice is
// shown first, and each slice is held for HOLD clock cycles. When another
// result is waiting, the next one starts the cycle after the last slice-0
// cycle, so there is no gap in valid.
module result_display_sequencer #(
    parameter int DEPTH = 4,
    parameter int HOLD  = 100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] writeData,
    input  logic        writeEnable,
    output logic [15:0] displayValue,
    output logic [1:0]  sliceIndex,
    output logic        valid,
    output logic        empty,
    output logic        full,
    output logic        dropped
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;

    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    // Selects one 16-bit slice of a 64-bit result (3 = bits 63:48).
    function automatic logic [15:0] slice_of(input logic [63:0] value,
                                             input logic [1:0]  idx);
        logic [15:0] sel;
        case (idx)
            2'd3:    sel = value[63:48];
            2'd2:    sel = value[47:32];
            2'd1:    sel = value[31:16];
            2'd0:    sel = value[15:0];
            default: sel = 16'h0000;
        endcase
        return sel;
    endfunction

    // FIFO storage and bookkeeping
    logic [63:0]       mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              dropped_q, dropped_d;

    // Display sequencing
    state_t            state_q, state_d;
    logic [63:0]       shadow_q, shadow_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [1:0]        slice_q, slice_d;
    logic [15:0]       disp_q, disp_d;
    logic              valid_q, valid_d;

    // Combinational handshakes
    logic              pop_s;
    logic              push_s;
    logic              hold_done_s;
    logic [63:0]       head_s;

    // Sequencer FSM: decides when to pop, which slice to show, and the hold timing.
    always_comb begin
        head_s      = mem_q[rd_ptr_q];
        hold_done_s = (hold_cnt_q == HOLD_LAST);
        state_d     = state_q;
        shadow_d    = shadow_q;
        hold_cnt_d  = hold_cnt_q;
        slice_d     = slice_q;
        disp_d      = disp_q;
        valid_d     = valid_q;
        pop_s       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                if (!empty_q) begin
                    // Load the head entry and start on its top slice.
                    pop_s      = 1'b1;
                    shadow_d   = head_s;
                    slice_d    = 2'd3;
                    disp_d     = head_s[63:48];
                    hold_cnt_d = {HOLD_W{1'b0}};
                    valid_d    = 1'b1;
                    state_d    = ST_SHOW;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHOW: begin
                valid_d = 1'b1;
                if (!hold_done_s) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end else if (slice_q != 2'd0) begin
                    // Move to the next lower slice of the same result.
                    slice_d    = slice_q - 2'd1;
                    disp_d     = slice_of(shadow_q, slice_q - 2'd1);
                    hold_cnt_d = {HOLD_W{1'b0}};
                end else if (!empty_q) begin
                    // The last slice-0 cycle chains straight into the next result.
                    pop_s      = 1'b1;
                    shadow_d   = head_s;
                    slice_d    = 2'd3;
                    disp_d     = head_s[63:48];
                    hold_cnt_d = {HOLD_W{1'b0}};
                end else begin
                    // Nothing pending: drop valid and keep the last digits visible.
                    hold_cnt_d = {HOLD_W{1'b0}};
                    valid_d    = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO control: accept pushes, move pointers, update the occupancy count.
    always_comb begin
        // A full FIFO can still accept a push in a cycle where the FSM pops.
        push_s    = writeEnable && (!full_q || pop_s);
        dropped_d = writeEnable && full_q && !pop_s;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        empty_d = (count_d == {CNT_W{1'b0}});
        full_d  = (count_d == DEPTH_C);
    end

    // FIFO data array: written at the write pointer on each accepted push.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 64'h0;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= writeData;
        end
    end

    // State and output registers. Reset flushes the FIFO and returns to IDLE from any state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q   <= {PTR_W{1'b0}};
            wr_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            dropped_q  <= 1'b0;
            state_q    <= ST_IDLE;
            shadow_q   <= 64'h0;
            hold_cnt_q <= {HOLD_W{1'b0}};
            slice_q    <= 2'd0;
            disp_q     <= 16'h0000;
            valid_q    <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            dropped_q  <= dropped_d;
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            hold_cnt_q <= hold_cnt_d;
            slice_q    <= slice_d;
            disp_q     <= disp_d;
            valid_q    <= valid_d;
        end
    end

    assign displayValue = disp_q;
    assign sliceIndex   = slice_q;
    assign valid        = valid_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign dropped      = dropped_q;

endmodule

// File: tb/tb_result_display_sequencer.sv
// Directed self-checking bench for result_display_sequencer (HOLD=4, DEPTH=4).
// Inputs change 1 time unit after a rising edge. Outputs are sampled on the
// falling edge. Cycle c is the interval after the c-th rising edge of a scenario.
module tb_result_display_sequencer;

    logic        clk;
    logic        rst;
    logic [63:0] writeData;
    logic        writeEnable;
    logic [15:0] displayValue;
    logic [1:0]  sliceIndex;
    logic        valid;
    logic        empty;
    logic        full;
    logic        dropped;

    int n_checks = 0;
    int n_fail   = 0;

    result_display_sequencer #(
        .DEPTH(4),
        .HOLD (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .writeData   (writeData),
        .writeEnable (writeEnable),
        .displayValue(displayValue),
        .sliceIndex  (sliceIndex),
        .valid       (valid),
        .empty       (empty),
        .full        (full),
        .dropped     (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports any mismatch.
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // All outputs at their reset values.
    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_disp"},    64'(displayValue), 64'h0);
        check_eq({tag, "_slice"},   64'(sliceIndex),   64'd0);
        check_eq({tag, "_valid"},   64'(valid),        64'd0);
        check_eq({tag, "_empty"},   64'(empty),        64'd1);
        check_eq({tag, "_full"},    64'(full),         64'd0);
        check_eq({tag, "_dropped"}, 64'(dropped),      64'd0);
    endtask

    // If cycle c falls inside the 16-cycle window of a result starting at s,
    // check valid, the slice index and the displayed slice.
    task automatic check_show(input string tag, input int c, input int s, input logic [63:0] v);
        int          k;
        logic [63:0] sh;
        if (c >= s && c < s + 16) begin
            k  = 3 - (c - s) / 4;
            sh = v >> (16 * k);
            check_eq({tag, "_valid"}, 64'(valid),        64'd1);
            check_eq({tag, "_slice"}, 64'(sliceIndex),   64'(k));
            check_eq({tag, "_disp"},  64'(displayValue), {48'd0, sh[15:0]});
        end
    endtask

    // Watchdog: the bench must never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] a2;
        logic [63:0] a3;
        logic [63:0] b3;
        logic [63:0] v4 [6];
        logic [63:0] v5 [6];
        logic [63:0] v6 [3];
        logic [63:0] q6;

        rst         = 1'b0;
        writeEnable = 1'b0;
        writeData   = 64'h0;

        // 1. Reset held low while writeEnable toggles.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            writeEnable = ~writeEnable;
            writeData   = 64'hFEED_0000_0000_0000 + 64'(i);
            @(negedge clk);
            check_reset_outputs("s1_hold");
        end
        @(posedge clk); #1;
        rst         = 1'b1;
        writeEnable = 1'b0;
        writeData   = 64'h0;
        @(negedge clk);
        check_reset_outputs("s1_after");
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_outputs("s1_released");
        @(posedge clk); #1;

        // 2. Single result.
        a2 = 64'h0123_4567_89AB_CDEF;
        for (int c = 0; c < 20; c++) begin
            writeEnable = (c == 0);
            writeData   = (c == 0) ? a2 : 64'h0;
            @(negedge clk);
            if (c < 2)   check_eq("s2_valid_pre", 64'(valid), 64'd0);
            if (c == 1)  check_eq("s2_empty_c1",  64'(empty), 64'd0);
            if (c == 2)  check_eq("s2_empty_c2",  64'(empty), 64'd1);
            if (c == 2)  check_eq("s2_disp_c2",   64'(displayValue), 64'h0123);
            if (c == 6)  check_eq("s2_disp_c6",   64'(displayValue), 64'h4567);
            if (c == 10) check_eq("s2_disp_c10",  64'(displayValue), 64'h89AB);
            if (c == 14) check_eq("s2_disp_c14",  64'(displayValue), 64'hCDEF);
            if (c == 17) check_eq("s2_disp_c17",  64'(displayValue), 64'hCDEF);
            check_show("s2", c, 2, a2);
            if (c >= 18) begin
                check_eq("s2_valid_end", 64'(valid),        64'd0);
                check_eq("s2_disp_end",  64'(displayValue), 64'hCDEF);
                check_eq("s2_slice_end", 64'(sliceIndex),   64'd0);
            end
            @(posedge clk); #1;
        end
        writeEnable = 1'b0;

        // 3. Back-to-back results: no gap in valid between them.
        a3 = 64'h1111_2222_3333_4444;
        b3 = 64'hAAAA_BBBB_CCCC_DDDD;
        for (int c = 0; c < 36; c++) begin
            writeEnable = (c < 2);
            writeData   = (c == 0) ? a3 : ((c == 1) ? b3 : 64'h0);
            @(negedge clk);
            if (c == 2)  check_eq("s3_empty_c2", 64'(empty), 64'd0);
            if (c == 18) check_eq("s3_disp_c18", 64'(displayValue), 64'hAAAA);
            check_show("s3a", c, 2, a3);
            check_show("s3b", c, 18, b3);
            if (c >= 34) begin
                check_eq("s3_valid_end", 64'(valid),        64'd0);
                check_eq("s3_disp_end",  64'(displayValue), 64'hDDDD);
            end
            @(posedge clk); #1;
        end
        writeEnable = 1'b0;

        // 4. Overflow: six pushes from empty, the sixth is rejected.
        v4[0] = 64'h0000_1000_2000_3000;
        v4[1] = 64'h0101_1101_2101_3101;
        v4[2] = 64'h0202_1202_2202_3202;
        v4[3] = 64'h0303_1303_2303_3303;
        v4[4] = 64'h0404_1404_2404_3404;
        v4[5] = 64'h0505_1505_2505_3505;
        for (int c = 0; c < 85; c++) begin
            writeEnable = (c < 6);
            writeData   = (c < 6) ? v4[c] : 64'h0;
            @(negedge clk);
            check_eq("s4_full",    64'(full),    (c >= 5 && c <= 17) ? 64'd1 : 64'd0);
            check_eq("s4_dropped", 64'(dropped), (c == 6) ? 64'd1 : 64'd0);
            for (int k = 0; k < 5; k++) begin
                check_show("s4", c, 2 + 16 * k, v4[k]);
            end
            if (c >= 82) begin
                check_eq("s4_valid_end", 64'(valid),        64'd0);
                check_eq("s4_disp_end",  64'(displayValue), 64'h3404);
            end
            @(posedge clk); #1;
        end
        writeEnable = 1'b0;

        // 5. Push into a full FIFO on the cycle the sequencer pops.
        v5[0] = 64'h5000_5001_5002_5003;
        v5[1] = 64'h5110_5111_5112_5113;
        v5[2] = 64'h5220_5221_5222_5223;
        v5[3] = 64'h5330_5331_5332_5333;
        v5[4] = 64'h5440_5441_5442_5443;
        v5[5] = 64'h5EE0_5EE1_5EE2_5EE3;
        for (int c = 0; c < 100; c++) begin
            writeEnable = (c < 5) || (c == 17);
            writeData   = (c < 5) ? v5[c] : ((c == 17) ? v5[5] : 64'h0);
            @(negedge clk);
            check_eq("s5_full",    64'(full),    (c >= 5 && c <= 33) ? 64'd1 : 64'd0);
            check_eq("s5_dropped", 64'(dropped), 64'd0);
            for (int k = 0; k < 6; k++) begin
                check_show("s5", c, 2 + 16 * k, v5[k]);
            end
            if (c >= 98) check_eq("s5_valid_end", 64'(valid), 64'd0);
            @(posedge clk); #1;
        end
        writeEnable = 1'b0;

        // 6. Reset for one cycle during slice 2, with two entries queued and a push attempted.
        v6[0] = 64'h6000_6100_6200_6300;
        v6[1] = 64'h6011_6111_6211_6311;
        v6[2] = 64'h6022_6122_6222_6322;
        q6    = 64'h7777_8888_9999_0000;
        for (int c = 0; c < 30; c++) begin
            rst         = (c == 7) ? 1'b0 : 1'b1;
            writeEnable = (c < 3) || (c == 7) || (c == 10);
            writeData   = (c < 3) ? v6[c] : ((c == 7) ? 64'hBAD0_BAD0_BAD0_BAD0 :
                          ((c == 10) ? q6 : 64'h0));
            @(negedge clk);
            if (c < 8) check_show("s6_pre", c, 2, v6[0]);
            if (c == 7) check_eq("s6_slice_c7", 64'(sliceIndex), 64'd2);
            if (c == 8) check_reset_outputs("s6_rst");
            if (c >= 8 && c <= 11) check_eq("s6_valid_gap", 64'(valid), 64'd0);
            if (c == 11) check_eq("s6_empty_c11", 64'(empty), 64'd0);
            check_show("s6_post", c, 12, q6);
            if (c >= 28) begin
                check_eq("s6_valid_end", 64'(valid),        64'd0);
                check_eq("s6_disp_end",  64'(displayValue), 64'h0000);
                check_eq("s6_empty_end", 64'(empty),        64'd1);
            end
            @(posedge clk); #1;
        end
        rst         = 1'b1;
        writeEnable = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
